// File: rtl/block_matching_pkg.sv
// Shared types and helpers for the block-matching pipeline: block index
// layout, scan FSM states and block-grid geometry.
package block_matching_pkg;

    localparam int BLK_COL_W = 6;
    localparam int BLK_ROW_W = 10;

    typedef struct packed {
        logic [BLK_ROW_W-1:0] row;
        logic [BLK_COL_W-1:0] col;
    } blk_index_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } scan_state_t;

    // Number of block columns across a frame.
    function automatic int calc_num_cols(input int frame_w, input int blk_w);
        return frame_w / blk_w;
    endfunction

endpackage

// File: rtl/blk_pos_counter.sv
// Raster-order block position counter: col wraps at num_cols and carries
// into row; the whole position wraps to (0,0) after the last block.
// clr has priority over inc.
module blk_pos_counter
    import block_matching_pkg::*;
#(
    parameter int num_cols = 19,
    parameter int num_rows = 15
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clr,
    input  logic                 inc,
    output logic [BLK_COL_W-1:0] col,
    output logic [BLK_ROW_W-1:0] row,
    output logic                 col_last,
    output logic                 last
);

    assign col_last = (col == BLK_COL_W'(num_cols - 1));
    assign last     = col_last && (row == BLK_ROW_W'(num_rows - 1));

    // Advance the position on each increment, wrapping column into row.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col <= '0;
            row <= '0;
        end else if (clr) begin
            col <= '0;
            row <= '0;
        end else if (inc) begin
            if (col_last) begin
                col <= '0;
                row <= last ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/block_scan_sequencer.sv
// Issues the raster-order block index stream for one frame with a
// valid/ready handshake, gated by the number of buffered block rows.
// Optional build macro: BLOCK_SEQ_STALL_CNT_EN adds the stall_cnt output.
module block_scan_sequencer
    import block_matching_pkg::*;
#(
    parameter int frame_w = 304,
    parameter int frame_h = 240,
    parameter int blk_w   = 16,
    parameter int blk_h   = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        abort,
    input  logic [9:0]  rows_avail,
    output logic [15:0] blk_index,
    output logic        blk_valid,
    input  logic        blk_ready,
    output logic        busy,
    output logic        frame_done
`ifdef BLOCK_SEQ_STALL_CNT_EN
    ,
    output logic [23:0] stall_cnt
`endif
);

    localparam int num_cols = calc_num_cols(frame_w, blk_w);
    localparam int num_rows = frame_h / blk_h;

    generate
        if (num_cols > 64 || num_rows > 1024 ||
            (frame_w % blk_w) != 0 || (frame_h % blk_h) != 0) begin : g_bad_geometry
            $error("block_scan_sequencer: unsupported frame/block geometry");
        end
    endgenerate

    scan_state_t          state;
    logic [BLK_COL_W-1:0] col;
    logic [BLK_ROW_W-1:0] row;
    logic [BLK_ROW_W-1:0] row_next;
    logic                 col_last;
    logic                 last;
    logic                 xfer;
    logic                 start_acc;
    logic                 cnt_clr;
    logic                 cnt_inc;
    blk_index_t           idx;

    assign xfer      = (state == RUN) && blk_valid && blk_ready;
    assign start_acc = (state == IDLE) && start;
    // abort wins over a simultaneous transfer
    assign cnt_clr   = start_acc || ((state == RUN) && abort);
    assign cnt_inc   = xfer && !abort;

    // Row of the block that will be presented after this cycle; valid for
    // the next index must be judged against it so row boundaries stream
    // at full rate without presenting an unbuffered row.
    assign row_next  = (xfer && col_last) ? row + 1'b1 : row;

    blk_pos_counter #(
        .num_cols (num_cols),
        .num_rows (num_rows)
    ) u_pos (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr      (cnt_clr),
        .inc      (cnt_inc),
        .col      (col),
        .row      (row),
        .col_last (col_last),
        .last     (last)
    );

    assign idx       = '{row: row, col: col};
    assign blk_index = idx;

    // Scan control FSM with registered valid/busy/frame_done.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            blk_valid  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    frame_done <= 1'b0;
                    blk_valid  <= 1'b0;
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state     <= IDLE;
                        blk_valid <= 1'b0;
                        busy      <= 1'b0;
                    end else if (xfer && last) begin
                        state      <= DONE;
                        blk_valid  <= 1'b0;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                    end else begin
                        blk_valid <= (row_next < rows_avail);
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    frame_done <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    blk_valid  <= 1'b0;
                    busy       <= 1'b0;
                    frame_done <= 1'b0;
                end
            endcase
        end
    end

`ifdef BLOCK_SEQ_STALL_CNT_EN
    // Count RUN cycles where a valid block waits on downstream; saturating.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
        end else if (start_acc) begin
            stall_cnt <= '0;
        end else if ((state == RUN) && blk_valid && !blk_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_block_scan_sequencer.sv
// Directed bench for block_scan_sequencer: full frame, row gating,
// backpressure, async reset mid-frame, abort on the final block and
// start pulses in RUN/DONE.
module tb_block_scan_sequencer;

    localparam int NC = 19;
    localparam int NR = 15;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        abort;
    logic [9:0]  rows_avail;
    logic [15:0] blk_index;
    logic        blk_valid;
    logic        blk_ready;
    logic        busy;
    logic        frame_done;
`ifdef BLOCK_SEQ_STALL_CNT_EN
    logic [23:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int er;
    int ec;

    block_scan_sequencer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .abort      (abort),
        .rows_avail (rows_avail),
        .blk_index  (blk_index),
        .blk_valid  (blk_valid),
        .blk_ready  (blk_ready),
        .busy       (busy),
        .frame_done (frame_done)
`ifdef BLOCK_SEQ_STALL_CNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, 32'(blk_valid), 32'd0);
        chk({tag, "_busy"},  32'(busy),      32'd0);
        chk({tag, "_done"},  32'(frame_done), 32'd0);
        chk({tag, "_index"}, 32'(blk_index), 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected index packing and raster advance, independent of the DUT.
    function automatic logic [31:0] pack(input int r, input int c);
        return 32'((r << 6) | c);
    endfunction

    task automatic run_blocks(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            chk({tag, "_valid"}, 32'(blk_valid), 32'd1);
            chk({tag, "_index"}, 32'(blk_index), pack(er, ec));
            tick();
            if (ec == NC - 1) begin
                ec = 0;
                er = (er == NR - 1) ? 0 : er + 1;
            end else begin
                ec = ec + 1;
            end
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        er = 0;
        ec = 0;
    endtask

    initial begin
        reset_n    = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        rows_avail = 10'd0;
        blk_ready  = 1'b0;
        #1;
        chk_idle("reset");
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        chk_idle("post_reset");

        // Full frame at full rate.
        rows_avail = 10'd15;
        blk_ready  = 1'b1;
        do_start();
        chk("ff_busy", 32'(busy), 32'd1);
        chk("ff_lat_valid", 32'(blk_valid), 32'd0);
        tick();
        run_blocks(NC, "ff_row0");
        chk("ff_wrap_index", 32'(blk_index), pack(1, 0));
        run_blocks(NR * NC - NC, "ff");
        chk("ff_done", 32'(frame_done), 32'd1);
        chk("ff_done_busy", 32'(busy), 32'd0);
        chk("ff_done_valid", 32'(blk_valid), 32'd0);
        start = 1'b1;               // ignored in DONE
        tick();
        start = 1'b0;
        chk("ff_done_once", 32'(frame_done), 32'd0);
        tick();
        chk_idle("ff_no_restart");

        // Row gating.
        rows_avail = 10'd0;
        blk_ready  = 1'b0;
        do_start();
        for (int k = 0; k < 10; k++) begin
            chk("gate_wait_valid", 32'(blk_valid), 32'd0);
            tick();
        end
        rows_avail = 10'd1;
        chk("gate_before_change", 32'(blk_valid), 32'd0);
        tick();
        blk_ready = 1'b1;
        run_blocks(NC, "gate");
        chk("gate_drop_valid", 32'(blk_valid), 32'd0);
        chk("gate_hold_index", 32'(blk_index), pack(1, 0));
        start = 1'b1;               // ignored in RUN
        tick();
        start = 1'b0;
        chk("gate_start_ign_busy", 32'(busy), 32'd1);
        chk("gate_start_ign_index", 32'(blk_index), pack(1, 0));
        chk("gate_start_ign_valid", 32'(blk_valid), 32'd0);
        rows_avail = 10'd2;
        tick();
        chk("gate_row1_valid", 32'(blk_valid), 32'd1);
        chk("gate_row1_index", 32'(blk_index), pack(1, 0));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_idle("gate_abort");

        // Backpressure at (3,5).
        rows_avail = 10'd15;
        blk_ready  = 1'b1;
        do_start();
        tick();
        run_blocks(3 * NC + 5, "bp_pre");
        blk_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk("bp_hold_valid", 32'(blk_valid), 32'd1);
            chk("bp_hold_index", 32'(blk_index), pack(3, 5));
            tick();
        end
        blk_ready = 1'b1;
        chk("bp_release_index", 32'(blk_index), pack(3, 5));
        tick();
        ec = 6;
        chk("bp_after_index", 32'(blk_index), pack(3, 6));
`ifdef BLOCK_SEQ_STALL_CNT_EN
        chk("bp_stall_cnt", 32'(stall_cnt), 32'd2);
`endif

        // Async reset mid-frame at (7,9).
        run_blocks(4 * NC + 3, "rst_pre");
        chk("rst_at_index", 32'(blk_index), pack(7, 9));
        reset_n = 1'b0;
        #2;
        chk_idle("async_reset");
        reset_n = 1'b1;
        tick();
        chk_idle("rst_release");
        do_start();
        tick();
        run_blocks(1, "rst_restart");

        // Abort coinciding with the final-block transfer.
        abort = 1'b1;
        tick();
        abort = 1'b0;
        do_start();
        tick();
        run_blocks(NR * NC - 1, "ab_pre");
        chk("ab_final_index", 32'(blk_index), pack(14, 18));
        chk("ab_final_valid", 32'(blk_valid), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_idle("ab_next");
        tick();
        chk_idle("ab_no_done");
        do_start();
        chk("ab_restart_busy", 32'(busy), 32'd1);
        tick();
        run_blocks(2, "ab_restart");
`ifdef BLOCK_SEQ_STALL_CNT_EN
        chk("ab_stall_cleared", 32'(stall_cnt), 32'd0);
`endif
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_idle("final_abort");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
